// File: rtl/ysyx_24090003_ifu_sram.sv
// ---------------------------------------------------------------------------
// ysyx_24090003_ifu_sram
//
// Read-only instruction memory slave sitting directly upstream of the IFU.
// It speaks the AR/R half of AXI4-Lite and inserts a configurable access
// latency so that the IFU fetch handshake meets realistic memory timing.
//
// Latency L per request:
//   RAND_LAT = 0 : L = FIXED_LAT (1..255)
//   RAND_LAT = 1 : L = lfsr[2:0] + 1 (1..8), sampled on the AR handshake edge
// o_rvalid rises exactly L rising edges after the AR handshake edge, so two
// consecutive AR handshakes are at least L+2 cycles apart.
//
// Responses:
//   aligned address inside [MEM_BASE, MEM_BASE+MEM_SIZE) -> pmem_read, OKAY
//   misaligned or outside the window                     -> data 0, SLVERR
//
// Ports:
//   i_clk      in   1   clock, rising edge
//   i_rst_n    in   1   asynchronous active-low reset
//   i_arvalid  in   1   read-address valid from the IFU
//   o_arready  out  1   slave can take an address (IDLE only)
//   i_araddr   in   32  instruction byte address
//   o_rvalid   out  1   read data valid
//   i_rready   in   1   IFU accepts the read data
//   o_rdata    out  32  instruction word
//   o_rresp    out  2   2'b00 OKAY, 2'b10 SLVERR
//
// All outputs come straight from flops; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module ysyx_24090003_ifu_sram #(
  parameter int unsigned FIXED_LAT = 4,
  parameter bit          RAND_LAT  = 1'b0,
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE  = 32'h0800_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_arvalid,
  output logic        o_arready,
  input  logic [31:0] i_araddr,
  output logic        o_rvalid,
  input  logic        i_rready,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_rresp
);

  // -------------------------------------------------------------------------
  // Backing store access
  // -------------------------------------------------------------------------
  // Memory image: the reset vector holds 0x00000413 (addi s0, zero, 0), every
  // other word is derived from its own address so stale or misrouted data is
  // easy to spot.
  function automatic int pmem_read(input int paddr);
    if (paddr == 32'h8000_0000) begin
      return 32'h0000_0413;
    end
    return paddr ^ 32'h1357_9BDF;
  endfunction

  // -------------------------------------------------------------------------
  // State encoding
  // -------------------------------------------------------------------------
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [7:0]  lfsr;
  logic [31:0] req_addr;

  logic        lfsr_fb;
  logic [7:0]  lat;
  logic        ar_hs;
  logic        r_hs;
  logic [32:0] win_lo;
  logic [32:0] win_hi;
  logic [32:0] req_addr_ext;
  logic        addr_ok;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  always_comb begin
    // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1
    lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    if (RAND_LAT) begin
      lat = {5'd0, lfsr[2:0]} + 8'd1;
    end else begin
      lat = 8'(FIXED_LAT);
    end

    ar_hs = i_arvalid & o_arready;
    r_hs  = o_rvalid & i_rready;

    // 33-bit window bounds so MEM_BASE + MEM_SIZE cannot wrap to a small value
    win_lo       = {1'b0, MEM_BASE};
    win_hi       = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
    req_addr_ext = {1'b0, req_addr};
    addr_ok      = (req_addr[1:0] == 2'b00) &&
                   (req_addr_ext >= win_lo) &&
                   (req_addr_ext < win_hi);
  end

  // -------------------------------------------------------------------------
  // LFSR: free-running out of reset, independent of the request FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
    end
  end

  // -------------------------------------------------------------------------
  // Request FSM and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      req_addr  <= 32'd0;
      o_arready <= 1'b1;
      o_rvalid  <= 1'b0;
      o_rdata   <= 32'd0;
      o_rresp   <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs) begin
            // Address is captured here; later i_araddr changes do not matter.
            req_addr  <= i_araddr;
            cnt       <= lat;
            o_arready <= 1'b0;
            state     <= WAIT;
          end
        end

        WAIT: begin
          if (cnt == 8'd1) begin
            state    <= RESP;
            o_rvalid <= 1'b1;
            // Memory is touched only here and only for legal addresses.
            if (addr_ok) begin
              o_rdata <= pmem_read(req_addr);
              o_rresp <= RESP_OKAY;
            end else begin
              o_rdata <= 32'd0;
              o_rresp <= RESP_SLVERR;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        RESP: begin
          // rdata/rresp are left untouched so they stay stable while stalled.
          if (r_hs) begin
            o_rvalid  <= 1'b0;
            o_arready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          o_arready <= 1'b1;
          o_rvalid  <= 1'b0;
        end
      endcase
    end
  end

endmodule
